// File: rtl/sqrt_pkg.sv
// Shared definitions for the fixed-point square-root engine.
//   state_e   : engine control states (idle / iterating / result held)
//   calc_iter : number of restoring-sqrt iterations for a given format,
//               one root bit per iteration over WIDTH+FBITS radicand bits
package sqrt_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int calc_iter(input int width, input int fbits);
    return (width + fbits) / 2;
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// One combinational restoring square-root iteration.
//   i_acc/o_acc   : partial remainder before/after this iteration
//   i_rad/o_rad   : radicand shift register; the top two bits are consumed
//   i_root/o_root : partial root; one new bit is shifted in at the LSB
module sqrt_step #(
  parameter int ITER = 24
) (
  input  logic [ITER+1:0]   i_acc,
  input  logic [2*ITER-1:0] i_rad,
  input  logic [ITER-1:0]   i_root,
  output logic [ITER+1:0]   o_acc,
  output logic [2*ITER-1:0] o_rad,
  output logic [ITER-1:0]   o_root
);

  localparam int AW = ITER + 2;

  logic        [AW+1:0] acc_sh;
  logic signed [AW+1:0] trial;
  logic                 keep;

  always_comb begin
    // Bring down the next radicand bit pair, then try subtracting 4q+1.
    acc_sh = {i_acc, i_rad[2*ITER-1 -: 2]};
    trial  = signed'(acc_sh - {2'b00, i_root, 2'b01});
    keep   = (trial >= 0);
    o_acc  = keep ? AW'(trial) : AW'(acc_sh);
    o_root = {i_root[ITER-2:0], keep};
    o_rad  = {i_rad[2*ITER-3:0], 2'b00};
  end

endmodule

// File: rtl/fixed_sqrt_engine.sv
// Iterative unsigned fixed-point square root with valid/ready handshakes.
//   i_valid/o_ready/i_rad/i_tag : radicand input, accepted only in IDLE
//   o_valid/i_ready             : result handshake, result held until taken
//   o_root                      : root in the radicand's fixed-point format
//   o_rem                       : i_rad*2^FBITS - q^2 for the truncated root q
//   o_rounded                   : root was bumped up by round-to-nearest
//   o_tag                       : tag captured with the radicand
//   o_busy                      : iterations in progress
// STEPS iterations are unrolled per clock, so latency is ITER/STEPS cycles.
module fixed_sqrt_engine
  import sqrt_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FBITS = 16,
  parameter int STEPS = 1,
  parameter int ROUND = 0,
  parameter int TAGW  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_rad,
  input  logic [TAGW-1:0]  i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_root,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_rounded,
  output logic [TAGW-1:0]  o_tag,
  output logic             o_busy
);

  localparam int ITER = calc_iter(WIDTH, FBITS);
  localparam int NCYC = ITER / STEPS;
  localparam int CW   = $clog2(NCYC + 1);
  localparam int AW   = ITER + 2;
  localparam int RW   = 2 * ITER;

  if (((WIDTH + FBITS) % 2) != 0 || (ITER % STEPS) != 0) begin : g_bad_cfg
    $error("fixed_sqrt_engine: WIDTH+FBITS must be even and ITER divisible by STEPS");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TAGW-1:0]  tag_q, tag_d;
  logic [WIDTH-1:0] res_root_q, res_root_d;
  logic [WIDTH-1:0] res_rem_q, res_rem_d;
  logic             res_rnd_q, res_rnd_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [RW-1:0]    rad_q, rad_d;
  logic [ITER-1:0]  root_q, root_d;

  logic [AW-1:0]    acc_c  [STEPS+1];
  logic [RW-1:0]    rad_c  [STEPS+1];
  logic [ITER-1:0]  root_c [STEPS+1];

  // Returns {rounded_flag, root}; saturates instead of wrapping to zero.
  function automatic logic [WIDTH:0] round_root(input logic [ITER-1:0] q,
                                                input logic [AW-1:0]   rem);
    logic [WIDTH-1:0] qw;
    qw = WIDTH'(q);
    if (ROUND == 0 || rem <= {2'b00, q}) return {1'b0, qw};
    if (&qw) return {1'b0, qw};
    return {1'b1, qw + WIDTH'(1)};
  endfunction

  assign acc_c[0]  = acc_q;
  assign rad_c[0]  = rad_q;
  assign root_c[0] = root_q;

  for (genvar s = 0; s < STEPS; s++) begin : g_step
    sqrt_step #(.ITER(ITER)) u_step (
      .i_acc  (acc_c[s]),
      .i_rad  (rad_c[s]),
      .i_root (root_c[s]),
      .o_acc  (acc_c[s+1]),
      .o_rad  (rad_c[s+1]),
      .o_root (root_c[s+1])
    );
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tag_d      = tag_q;
    res_root_d = res_root_q;
    res_rem_d  = res_rem_q;
    res_rnd_d  = res_rnd_q;
    acc_d      = acc_q;
    rad_d      = rad_q;
    root_d     = root_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          state_d = S_CALC;
          cnt_d   = '0;
          tag_d   = i_tag;
          acc_d   = '0;
          root_d  = '0;
          rad_d   = RW'(i_rad) << FBITS;
        end
      end
      S_CALC: begin
        acc_d  = acc_c[STEPS];
        rad_d  = rad_c[STEPS];
        root_d = root_c[STEPS];
        if (cnt_q == CW'(NCYC - 1)) begin
          state_d                 = S_DONE;
          {res_rnd_d, res_root_d} = round_root(root_c[STEPS], acc_c[STEPS]);
          res_rem_d               = WIDTH'(acc_c[STEPS]);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and visible result registers: cleared by reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      tag_q      <= '0;
      res_root_q <= '0;
      res_rem_q  <= '0;
      res_rnd_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tag_q      <= tag_d;
      res_root_q <= res_root_d;
      res_rem_q  <= res_rem_d;
      res_rnd_q  <= res_rnd_d;
    end
  end

  // Iteration datapath: always reloaded on acceptance, so no reset needed.
  always_ff @(posedge i_clk) begin
    acc_q  <= acc_d;
    rad_q  <= rad_d;
    root_q <= root_d;
  end

  assign o_ready   = (state_q == S_IDLE);
  assign o_busy    = (state_q == S_CALC);
  assign o_valid   = (state_q == S_DONE);
  assign o_root    = res_root_q;
  assign o_rem     = res_rem_q;
  assign o_rounded = res_rnd_q;
  assign o_tag     = tag_q;

endmodule

// File: tb/tb_fixed_sqrt_engine.sv
// Bench for fixed_sqrt_engine: three instances (defaults, ROUND=1, STEPS=4)
// driven with directed and random radicands, checked against a reference
// square root computed from real-valued sqrt with integer correction.
module tb_fixed_sqrt_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rad_in;
  logic [3:0]  tag_in;
  logic        vld [3];
  logic        rdy [3];
  logic        o_ready_a [3];
  logic        o_valid_a [3];
  logic [31:0] o_root_a [3];
  logic [31:0] o_rem_a [3];
  logic        o_rnd_a [3];
  logic [3:0]  o_tag_a [3];
  logic        o_busy_a [3];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fixed_sqrt_engine u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld[0]), .o_ready(o_ready_a[0]),
    .i_rad(rad_in), .i_tag(tag_in), .o_valid(o_valid_a[0]), .i_ready(rdy[0]),
    .o_root(o_root_a[0]), .o_rem(o_rem_a[0]), .o_rounded(o_rnd_a[0]),
    .o_tag(o_tag_a[0]), .o_busy(o_busy_a[0]));

  fixed_sqrt_engine #(.ROUND(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld[1]), .o_ready(o_ready_a[1]),
    .i_rad(rad_in), .i_tag(tag_in), .o_valid(o_valid_a[1]), .i_ready(rdy[1]),
    .o_root(o_root_a[1]), .o_rem(o_rem_a[1]), .o_rounded(o_rnd_a[1]),
    .o_tag(o_tag_a[1]), .o_busy(o_busy_a[1]));

  fixed_sqrt_engine #(.STEPS(4)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld[2]), .o_ready(o_ready_a[2]),
    .i_rad(rad_in), .i_tag(tag_in), .o_valid(o_valid_a[2]), .i_ready(rdy[2]),
    .o_root(o_root_a[2]), .o_rem(o_rem_a[2]), .o_rounded(o_rnd_a[2]),
    .o_tag(o_tag_a[2]), .o_busy(o_busy_a[2]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: X = rad * 2^16, q = floor(sqrt(X)), rem = X - q^2.
  task automatic model(input logic [31:0] rad, input bit rnd,
                       output logic [31:0] er, output logic [31:0] erem,
                       output logic ernd);
    longint unsigned x, q, r;
    x = {16'h0, rad, 16'h0};
    q = longint'($rtoi($sqrt(real'(x))));
    while (q * q > x) q--;
    while ((q + 1) * (q + 1) <= x) q++;
    r    = x - q * q;
    erem = r[31:0];
    if (rnd && r > q && q < 64'hFFFF_FFFF) begin
      er   = 32'(q + 1);
      ernd = 1'b1;
    end else begin
      er   = q[31:0];
      ernd = 1'b0;
    end
  endtask

  task automatic start(input int d, input logic [31:0] rad, input logic [3:0] tag);
    chk("accept_ready", 64'(o_ready_a[d]), 64'd1);
    rad_in = rad;
    tag_in = tag;
    vld[d] = 1'b1;
    @(posedge clk); #1;
    vld[d] = 1'b0;
    chk("busy_after_accept", 64'(o_busy_a[d]), 64'd1);
  endtask

  task automatic wait_done(input int d, output int lat);
    lat = 0;
    while (!o_valid_a[d] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_op(input int d, input logic [31:0] rad, input logic [3:0] tag,
                       output logic [31:0] got_root, output logic [31:0] got_rem,
                       output logic got_rnd);
    int lat;
    logic [31:0] er, erem;
    logic ernd;
    model(rad, d == 1, er, erem, ernd);
    start(d, rad, tag);
    wait_done(d, lat);
    chk("latency", 64'(lat), (d == 2) ? 64'd6 : 64'd24);
    chk("root", 64'(o_root_a[d]), 64'(er));
    chk("rem", 64'(o_rem_a[d]), 64'(erem));
    chk("rounded", 64'(o_rnd_a[d]), 64'(ernd));
    chk("tag", 64'(o_tag_a[d]), 64'(tag));
    chk("ready_in_done", 64'(o_ready_a[d]), 64'd0);
    got_root = o_root_a[d];
    got_rem  = o_rem_a[d];
    got_rnd  = o_rnd_a[d];
    rdy[d] = 1'b1;
    @(posedge clk); #1;
    rdy[d] = 1'b0;
    chk("valid_after_take", 64'(o_valid_a[d]), 64'd0);
    chk("ready_after_take", 64'(o_ready_a[d]), 64'd1);
  endtask

  initial begin
    logic [31:0] gr, gm, er, erem, hr;
    logic        gd, ernd;
    int          lat, seen;

    rst_n  = 1'b0;
    rad_in = '0;
    tag_in = '0;
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0;
      rdy[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(o_ready_a[0]), 64'd1);
    chk("rst_valid", 64'(o_valid_a[0]), 64'd0);
    chk("rst_busy", 64'(o_busy_a[0]), 64'd0);
    chk("rst_root", 64'(o_root_a[0]), 64'd0);
    chk("rst_rem", 64'(o_rem_a[0]), 64'd0);
    chk("rst_tag", 64'(o_tag_a[0]), 64'd0);
    chk("rst_rounded", 64'(o_rnd_a[0]), 64'd0);

    // Release mid-cycle; the very next rising edge must accept.
    @(negedge clk);
    rst_n = 1'b1;
    do_op(0, 32'h0004_0000, 4'h5, gr, gm, gd);
    chk("sqrt4_root", 64'(gr), 64'h0002_0000);
    chk("sqrt4_rem", 64'(gm), 64'd0);

    do_op(0, 32'h0002_0000, 4'h3, gr, gm, gd);
    chk("sqrt2_root", 64'(gr), 64'h0001_6A09);
    chk("sqrt2_rem", 64'(gm), 64'h0002_8BAF);
    chk("sqrt2_rounded", 64'(gd), 64'd0);

    do_op(1, 32'h0002_0000, 4'h7, gr, gm, gd);
    chk("sqrt2r_root", 64'(gr), 64'h0001_6A0A);
    chk("sqrt2r_rem", 64'(gm), 64'h0002_8BAF);
    chk("sqrt2r_rounded", 64'(gd), 64'd1);

    do_op(1, 32'h0004_0000, 4'h1, gr, gm, gd);
    chk("sqrt4r_rounded", 64'(gd), 64'd0);

    do_op(0, 32'h0000_0000, 4'hA, gr, gm, gd);
    chk("zero_root", 64'(gr), 64'd0);
    chk("zero_rem", 64'(gm), 64'd0);

    do_op(0, 32'hFFFF_FFFF, 4'hF, gr, gm, gd);
    chk("max_root", 64'(gr), 64'h00FF_FFFF);
    chk("max_rem", 64'(gm), 64'h01FE_FFFF);

    do_op(2, 32'hFFFF_FFFF, 4'hE, gr, gm, gd);
    chk("max4_root", 64'(gr), 64'h00FF_FFFF);
    chk("max4_rem", 64'(gm), 64'h01FE_FFFF);

    do_op(0, 32'h0000_0001, 4'h2, gr, gm, gd);
    do_op(0, 32'h0001_0000, 4'h4, gr, gm, gd);

    for (int i = 0; i < 6; i++) do_op(0, $urandom, 4'($urandom), gr, gm, gd);
    for (int i = 0; i < 4; i++) do_op(1, $urandom, 4'($urandom), gr, gm, gd);
    for (int i = 0; i < 4; i++) do_op(2, $urandom, 4'($urandom), gr, gm, gd);

    // Result held under back-pressure; i_valid pulses in DONE are ignored.
    hr = $urandom;
    model(hr, 1'b0, er, erem, ernd);
    start(0, hr, 4'h9);
    wait_done(0, lat);
    chk("hold_latency", 64'(lat), 64'd24);
    for (int i = 0; i < 10; i++) begin
      vld[0] = i[0];
      rad_in = $urandom;
      tag_in = 4'h6;
      @(posedge clk); #1;
      chk("hold_valid", 64'(o_valid_a[0]), 64'd1);
      chk("hold_ready", 64'(o_ready_a[0]), 64'd0);
      chk("hold_root", 64'(o_root_a[0]), 64'(er));
      chk("hold_rem", 64'(o_rem_a[0]), 64'(erem));
      chk("hold_tag", 64'(o_tag_a[0]), 64'h9);
    end
    vld[0] = 1'b0;
    rdy[0] = 1'b1;
    @(posedge clk); #1;
    rdy[0] = 1'b0;
    chk("hold_release_valid", 64'(o_valid_a[0]), 64'd0);
    chk("hold_release_ready", 64'(o_ready_a[0]), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_no_restart", 64'(o_busy_a[0]), 64'd0);

    // Reset in the middle of CALC discards the operation.
    start(0, 32'h1234_5678, 4'hC);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(o_busy_a[0]), 64'd0);
    chk("midrst_ready", 64'(o_ready_a[0]), 64'd1);
    chk("midrst_valid", 64'(o_valid_a[0]), 64'd0);
    chk("midrst_tag", 64'(o_tag_a[0]), 64'd0);
    chk("midrst_root", 64'(o_root_a[0]), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (o_valid_a[0]) seen++;
    end
    chk("midrst_no_valid", 64'(seen), 64'd0);
    do_op(0, 32'h0009_0000, 4'hB, gr, gm, gd);
    chk("post_rst_root", 64'(gr), 64'h0003_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fixed_sqrt_engine.md
FIXED_SQRT_ENGINE -- requirements
Module: fixed_sqrt_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 32, radicand/root/remainder width in bits.
REQ-002 SHALL have parameter FBITS, default 16, fractional bits of the fixed-point radicand and root.
REQ-003 SHALL have parameter STEPS, default 1, root bits resolved per clock (unrolled iterations).
REQ-004 SHALL have parameter ROUND, default 0; 0 = truncate, 1 = round-to-nearest.
REQ-005 SHALL have parameter TAGW, default 4, width of the pass-through tag.
REQ-006 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port i_valid  input  1  radicand offered.
REQ-009 SHALL have port o_ready  output  1  engine can accept a radicand.
REQ-010 SHALL have port i_rad  input  WIDTH  unsigned fixed-point radicand.
REQ-011 SHALL have port i_tag  input  TAGW  user tag, captured with i_rad.
REQ-012 SHALL have port o_valid  output  1  result presented.
REQ-013 SHALL have port i_ready  input  1  downstream accepts result.
REQ-014 SHALL have port o_root  output  WIDTH  root, same fixed-point format as i_rad.
REQ-015 SHALL have port o_rem  output  WIDTH  remainder of the truncated root.
REQ-016 SHALL have port o_rounded  output  1  root was incremented by rounding.
REQ-017 SHALL have port o_tag  output  TAGW  tag captured with the radicand.
REQ-018 SHALL have port o_busy  output  1  high in CALC state.

Function
REQ-019 SHALL compute ITER = (WIDTH+FBITS)/2 iterations; elaboration SHALL fail unless WIDTH+FBITS is even and ITER mod STEPS = 0.
REQ-020 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE.
REQ-021 IDLE: o_ready=1; on i_valid capture i_rad, i_tag, clear root/accumulator, reset the cycle counter, go to CALC.
REQ-022 CALC: o_ready=0; each cycle apply STEPS restoring-sqrt iterations (subtract {q,01} from accumulator, keep if non-negative, shift in next two radicand bits); after ITER/STEPS cycles go to DONE.
REQ-023 Latency SHALL be exactly ITER/STEPS cycles from the accepting edge to the edge asserting o_valid (24 for defaults).
REQ-024 DONE: o_valid=1; o_root/o_rem/o_rounded/o_tag SHALL hold stable until the edge where i_ready=1, then return to IDLE with o_valid=0.
REQ-025 No new input SHALL be accepted in CALC or DONE (o_ready=0); i_valid there is ignored.
REQ-026 Truncated root q SHALL equal floor(sqrt(i_rad * 2^FBITS)); o_rem SHALL equal i_rad*2^FBITS - q^2.
REQ-027 ROUND=1: if rem > q, o_root = q+1 and o_rounded=1, saturating at all-ones (o_rounded=0 when saturated); o_rem always refers to truncated q.
REQ-028 i_rad = 0 SHALL give o_root=0, o_rem=0, latency unchanged.

Reset
REQ-029 i_rst_n low SHALL immediately force IDLE, o_ready=1, o_valid=0, o_busy=0, o_rounded=0, o_root=0, o_rem=0, o_tag=0, counter=0.
REQ-030 Reset mid-CALC or mid-DONE SHALL discard the operation; no o_valid follows release.
REQ-031 First acceptance SHALL be possible on the first rising edge after i_rst_n deasserts.

Structure
REQ-032 Package sqrt_pkg SHALL hold the FSM state enum and the ITER-computation function.
REQ-033 Sub-module sqrt_step (combinational single iteration: accumulator, radicand, partial root in/out) SHALL be instantiated STEPS times in a chain.

Verification (defaults unless noted)
REQ-034 i_rad=0x0004_0000 (4.0) -> o_root=0x0002_0000, o_rem=0, o_valid 24 cycles after accept.
REQ-035 i_rad=0x0002_0000 -> o_root=0x0001_6A09, o_rem=0x0002_8BAF; ROUND=1 -> o_root=0x0001_6A0A, o_rounded=1.
REQ-036 i_rad=0xFFFF_FFFF -> o_root=0x00FF_FFFF, o_rem=0x01FE_FFFF; STEPS=4 -> same result, latency 6.
REQ-037 Result with i_ready=0 for 10 cycles -> outputs and o_tag stable, o_ready=0, i_valid pulses ignored; i_ready=1 -> IDLE next cycle.
REQ-038 i_rst_n low at CALC cycle 10 -> o_busy=0, o_ready=1 at once; no o_valid after release; next op correct.
